// File: rtl/nios2_oci_dct_pkg.sv
// Shared widths, FSM encoding and atom codes for the OCI DCT trace packer.
package nios2_oci_dct_pkg;

  localparam int ATOM_W         = 3;
  localparam int ATOMS_PER_WORD = 10;
  localparam int DCT_W          = ATOM_W * ATOMS_PER_WORD;
  localparam int CNT_W          = 4;

  typedef enum logic [2:0] {
    ACCUM,
    FULL_WAIT,
    FLUSH,
    DRAIN,
    ENDED
  } dct_state_t;

  typedef logic [ATOM_W-1:0] atom_t;

  // Codes 5..7 are reserved and are packed like any other atom.
  localparam atom_t ATOM_NONE      = 3'd0;
  localparam atom_t ATOM_TAKEN     = 3'd1;
  localparam atom_t ATOM_NOT_TAKEN = 3'd2;
  localparam atom_t ATOM_EXCEPTION = 3'd3;
  localparam atom_t ATOM_RETURN    = 3'd4;

  typedef struct packed {
    logic [DCT_W-1:0] data;
    logic [CNT_W-1:0] count;
  } dct_word_t;

endpackage

// File: rtl/nios2_oci_dct_out_reg.sv
// Single-entry valid/ready output register; a load may coincide with a drain.
module nios2_oci_dct_out_reg
  import nios2_oci_dct_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load,
  input  dct_word_t load_word,
  input  logic      word_ready,
  output logic      word_valid,
  output dct_word_t word
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_valid <= 1'b0;
      word       <= '0;
    end else if (load) begin
      word_valid <= 1'b1;
      word       <= load_word;
    end else if (word_valid && word_ready) begin
      word_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 3-bit trace atoms into 30-bit DCT words and handles the end-of-test flush.
module nios2_oci_dct_packer
  import nios2_oci_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom,
  output logic              atom_ready,
  input  logic              test_ending,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [DCT_W-1:0]  word_data,
  output logic [CNT_W-1:0]  word_count,
  output logic [DCT_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              test_has_ended,
  output logic              overflow
);

  dct_state_t       state_q, state_d;
  logic             te_q, te_rise;
  logic             accept, close, set_ended, out_free, full_next;
  logic [DCT_W-1:0] nxt_buf;
  logic [CNT_W-1:0] nxt_cnt;
  dct_word_t        out_word;

  assign atom_ready = (state_q == ACCUM) && (dct_count != CNT_W'(ATOMS_PER_WORD));
  assign accept     = atom_valid && atom_ready;
  assign te_rise    = test_ending && !te_q;
  assign out_free   = !word_valid || word_ready;
  assign full_next  = (nxt_cnt == CNT_W'(ATOMS_PER_WORD));

  // Buffer as it would look after this cycle's accept; every close loads from it.
  always_comb begin
    nxt_buf = dct_buffer;
    nxt_cnt = dct_count + CNT_W'(accept);
    if (accept)
      nxt_buf = dct_buffer | (DCT_W'(atom) << (ATOM_W * int'(dct_count)));
  end

  always_comb begin
    state_d   = state_q;
    close     = 1'b0;
    set_ended = 1'b0;
    case (state_q)
      ACCUM: begin
        // A flush edge covers a same-cycle atom, including one that fills the word.
        if (te_rise) begin
          if (nxt_cnt == '0) begin
            state_d = DRAIN;
          end else if (out_free) begin
            close   = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = FLUSH;
          end
        end else if (full_next) begin
          if (out_free) close = 1'b1;
          else          state_d = FULL_WAIT;
        end
      end
      FULL_WAIT: begin
        if (out_free) begin
          close   = 1'b1;
          state_d = te_rise ? DRAIN : ACCUM;
        end else if (te_rise) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (dct_count == '0) begin
          state_d = DRAIN;
        end else if (out_free) begin
          close   = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!word_valid) begin
          set_ended = 1'b1;
          state_d   = ENDED;
        end
      end
      ENDED:   state_d = ENDED;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ACCUM;
      te_q           <= 1'b0;
      dct_buffer     <= '0;
      dct_count      <= '0;
      test_has_ended <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      state_q <= state_d;
      te_q    <= test_ending;
      if (close) begin
        dct_buffer <= '0;
        dct_count  <= '0;
      end else begin
        dct_buffer <= nxt_buf;
        dct_count  <= nxt_cnt;
      end
      if (set_ended) test_has_ended <= 1'b1;
      if (atom_valid && !atom_ready && (state_q inside {ACCUM, FULL_WAIT, FLUSH}))
        overflow <= 1'b1;
    end
  end

  nios2_oci_dct_out_reg u_out_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (close),
    .load_word  ('{data: nxt_buf, count: nxt_cnt}),
    .word_ready (word_ready),
    .word_valid (word_valid),
    .word       (out_word)
  );

  assign word_data  = out_word.data;
  assign word_count = out_word.count;

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Bench for nios2_oci_dct_packer: vector table, corner sequences, random scoreboard.
module tb_nios2_oci_dct_packer;
  import nios2_oci_dct_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        atom_valid = 1'b0;
  logic [2:0]  atom = 3'd0;
  logic        atom_ready;
  logic        test_ending = 1'b0;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [29:0] word_data;
  logic [3:0]  word_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  nios2_oci_dct_packer dut (
    .clk(clk), .reset(reset), .atom_valid(atom_valid), .atom(atom),
    .atom_ready(atom_ready), .test_ending(test_ending), .word_valid(word_valid),
    .word_ready(word_ready), .word_data(word_data), .word_count(word_count),
    .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_has_ended(test_has_ended), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        av;
    logic [2:0]  a;
    logic        wr;
    logic        te;
    logic [3:0]  e_cnt;
    logic [29:0] e_buf;
    logic        e_wv;
    logic [29:0] e_wd;
    logic [3:0]  e_wc;
    logic        e_end;
    logic        e_ar;
  } vec_t;

  vec_t tbl[17];

  logic [29:0] got_d[$];
  logic [3:0]  got_c[$];
  logic [2:0]  acc_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [2:0] a, input logic wr,
                              input logic te, input logic [3:0] e_cnt,
                              input logic [29:0] e_buf, input logic e_wv,
                              input logic [29:0] e_wd, input logic [3:0] e_wc,
                              input logic e_end, input logic e_ar);
    vec_t v;
    v.av = av; v.a = a; v.wr = wr; v.te = te; v.e_cnt = e_cnt; v.e_buf = e_buf;
    v.e_wv = e_wv; v.e_wd = e_wd; v.e_wc = e_wc; v.e_end = e_end; v.e_ar = e_ar;
    return v;
  endfunction

  // Word value from a list of atoms: atom i lands in bits [3i+2:3i].
  function automatic logic [29:0] pack(input logic [2:0] q[$]);
    logic [29:0] p = '0;
    foreach (q[i]) p = p | (30'(q[i]) << (3 * i));
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    atom_valid = 1'b0;
    test_ending = 1'b0;
    word_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic collect(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (word_valid && word_ready) begin
        got_d.push_back(word_data);
        got_c.push_back(word_count);
      end
      step();
    end
  endtask

  // Reference: words are consecutive groups of ten accepted atoms; a flush emits the remainder.
  task automatic sb_word();
    logic [2:0] w[$];
    int n;
    n = (acc_q.size() >= 10) ? 10 : acc_q.size();
    for (int i = 0; i < n; i++) w.push_back(acc_q.pop_front());
    chk("rand_word_count", word_count, n);
    chk("rand_word_data", word_data, pack(w));
  endtask

  initial begin
    logic [29:0] acc;
    logic [2:0]  a;
    logic [2:0]  v[$];
    int          n, bad, wv_seen, ready_bad;
    logic        exp_ovf;

    // Vector table: ten atoms with a free output, then a 3-atom flush to the end.
    acc = '0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      a = (i % 2 == 0) ? ATOM_TAKEN : ATOM_NOT_TAKEN;
      acc = acc | (30'(a) << (3 * i));
      if (i < 9) tbl[n] = mk(1'b1, a, 1'b1, 1'b0, 4'(i + 1), acc, 1'b0, '0, '0, 1'b0, 1'b1);
      else       tbl[n] = mk(1'b1, a, 1'b1, 1'b0, 4'd0, '0, 1'b1, acc, 4'd10, 1'b0, 1'b1);
      n++;
    end
    tbl[n++] = mk(1'b0, 3'd0, 1'b1, 1'b0, 4'd0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    tbl[n++] = mk(1'b1, 3'd5, 1'b1, 1'b0, 4'd1, 30'd5, 1'b0, '0, '0, 1'b0, 1'b1);
    tbl[n++] = mk(1'b1, 3'd3, 1'b1, 1'b0, 4'd2, 30'((3 << 3) | 5), 1'b0, '0, '0, 1'b0, 1'b1);
    tbl[n++] = mk(1'b1, 3'd1, 1'b1, 1'b0, 4'd3, 30'((1 << 6) | (3 << 3) | 5), 1'b0, '0, '0, 1'b0, 1'b1);
    tbl[n++] = mk(1'b0, 3'd0, 1'b0, 1'b1, 4'd0, '0, 1'b1, 30'((1 << 6) | (3 << 3) | 5), 4'd3, 1'b0, 1'b0);
    tbl[n++] = mk(1'b0, 3'd0, 1'b1, 1'b1, 4'd0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    tbl[n++] = mk(1'b0, 3'd0, 1'b1, 1'b1, 4'd0, '0, 1'b0, '0, '0, 1'b1, 1'b0);

    // Reset state
    step();
    chk("rst_dct_count", dct_count, 0);
    chk("rst_dct_buffer", dct_buffer, 0);
    chk("rst_word_valid", word_valid, 0);
    chk("rst_word_data", word_data, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_ended", test_has_ended, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_atom_ready", atom_ready, 1);
    reset = 1'b0;

    foreach (tbl[r]) begin
      atom_valid = tbl[r].av; atom = tbl[r].a;
      word_ready = tbl[r].wr; test_ending = tbl[r].te;
      step();
      chk($sformatf("row%0d_dct_count", r), dct_count, tbl[r].e_cnt);
      chk($sformatf("row%0d_dct_buffer", r), dct_buffer, tbl[r].e_buf);
      chk($sformatf("row%0d_word_valid", r), word_valid, tbl[r].e_wv);
      if (tbl[r].e_wv) begin
        chk($sformatf("row%0d_word_data", r), word_data, tbl[r].e_wd);
        chk($sformatf("row%0d_word_count", r), word_count, tbl[r].e_wc);
      end
      chk($sformatf("row%0d_ended", r), test_has_ended, tbl[r].e_end);
      chk($sformatf("row%0d_atom_ready", r), atom_ready, tbl[r].e_ar);
    end

    // Backpressure: 20 atoms with a stalled FIFO, one overflowed offer, then drain both words.
    do_reset();
    v.delete();
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      v.push_back(3'($urandom_range(0, 7)));
      atom_valid = 1'b1; atom = v[k];
      @(negedge clk);
      if (!atom_ready) bad++;
      step();
    end
    chk("bp_ready_while_filling", bad, 0);
    chk("bp_ready_low_at_20", atom_ready, 0);
    chk("bp_count_held", dct_count, 10);
    chk("bp_first_word_held", word_valid, 1);
    chk("bp_no_overflow_yet", overflow, 0);
    atom = 3'd7;
    step();
    chk("bp_overflow_set", overflow, 1);
    chk("bp_count_after_ovf", dct_count, 10);
    atom_valid = 1'b0;
    word_ready = 1'b1;
    got_d.delete(); got_c.delete();
    collect(6);
    chk("bp_word_total", got_d.size(), 2);
    if (got_d.size() == 2) begin
      chk("bp_word0_data", got_d[0], pack(v[0:9]));
      chk("bp_word0_count", got_c[0], 10);
      chk("bp_word1_data", got_d[1], pack(v[10:19]));
      chk("bp_word1_count", got_c[1], 10);
    end
    chk("bp_count_after_drain", dct_count, 0);

    // Ninth-plus-one atom arrives on the flush edge: one 10-atom word, no empty word.
    do_reset();
    word_ready = 1'b1;
    v.delete();
    for (int k = 0; k < 10; k++) v.push_back(3'($urandom_range(0, 7)));
    for (int k = 0; k < 9; k++) begin
      atom_valid = 1'b1; atom = v[k];
      step();
    end
    atom = v[9];
    test_ending = 1'b1;
    step();
    atom_valid = 1'b0;
    chk("edge10_dct_count", dct_count, 0);
    chk("edge10_word_valid", word_valid, 1);
    got_d.delete(); got_c.delete();
    collect(6);
    chk("edge10_word_total", got_d.size(), 1);
    if (got_d.size() == 1) begin
      chk("edge10_word_data", got_d[0], pack(v));
      chk("edge10_word_count", got_c[0], 10);
    end
    chk("edge10_ended", test_has_ended, 1);

    // Flush with nothing buffered.
    do_reset();
    word_ready = 1'b1;
    test_ending = 1'b1;
    wv_seen = 0;
    for (int k = 0; k < 2; k++) begin
      step();
      if (word_valid) wv_seen++;
    end
    chk("empty_flush_no_word", wv_seen, 0);
    chk("empty_flush_ended", test_has_ended, 1);

    // Asynchronous reset while blocked with a full buffer.
    do_reset();
    atom_valid = 1'b1;
    for (int k = 0; k < 21; k++) begin
      atom = 3'(k + 1);
      step();
    end
    chk("rstfw_pre_overflow", overflow, 1);
    chk("rstfw_pre_count", dct_count, 10);
    #2;
    reset = 1'b1;
    #1;
    chk("rstfw_async_count", dct_count, 0);
    chk("rstfw_async_buffer", dct_buffer, 0);
    chk("rstfw_async_word_valid", word_valid, 0);
    chk("rstfw_async_word_data", word_data, 0);
    chk("rstfw_async_overflow", overflow, 0);
    atom_valid = 1'b0;
    step();
    reset = 1'b0;
    atom_valid = 1'b1; atom = 3'd6; word_ready = 1'b1;
    step();
    atom_valid = 1'b0;
    chk("rstfw_restart_count", dct_count, 1);
    chk("rstfw_restart_buffer", dct_buffer, 6);

    // Random traffic against the atom-stream scoreboard, then a final flush.
    do_reset();
    acc_q.delete();
    exp_ovf = 1'b0;
    ready_bad = 0;
    for (int c = 0; c < 800; c++) begin
      atom_valid = ($urandom % 4) != 0;
      atom = 3'($urandom);
      word_ready = ($urandom % 3) != 0;
      @(negedge clk);
      if (atom_ready != (dct_count != 4'd10)) ready_bad++;
      if (word_valid && word_ready) sb_word();
      if (atom_valid && atom_ready) acc_q.push_back(atom);
      if (atom_valid && !atom_ready) exp_ovf = 1'b1;
      step();
    end
    chk("rand_ready_rule", ready_bad, 0);
    chk("rand_overflow", overflow, exp_ovf);
    atom_valid = 1'b0;
    word_ready = 1'b1;
    test_ending = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (word_valid && word_ready) sb_word();
      step();
    end
    chk("rand_atoms_left", acc_q.size(), 0);
    chk("rand_ended", test_has_ended, 1);
    chk("rand_ended_ready", atom_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
